// File: rtl/pdp1_mem_ctrl.sv
// rtl/pdp1_mem_ctrl.sv - CPU-side core memory cycle sequencer (read, write, increment, indirect)
module pdp1_mem_ctrl #(
   parameter int MAX_DEFER = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        c_req,
   input  logic [0:1]  c_op,
   input  logic [0:11] c_adr,
   input  logic [0:17] c_wdata,
   output logic        c_busy,
   output logic        c_done,
   output logic [0:17] c_rdata,
   output logic [0:11] c_eadr,
   output logic        c_pos,
   output logic        c_err,
   output logic        mm_we,
   output logic [0:11] mm_adr,
   input  logic [0:17] mm_din,
   output logic [0:17] mm_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_IND
   } state_t;

   localparam logic [3:0] DEPTH_LAST = 4'(MAX_DEFER - 1);

   state_t      state_q, state_d;
   logic [0:11] adr_q, adr_d;
   logic [0:17] wdata_q, wdata_d;
   logic [3:0]  depth_q, depth_d;
   logic [0:17] c_rdata_q, c_rdata_d;
   logic [0:11] c_eadr_q, c_eadr_d;
   logic        c_done_q, c_done_d;
   logic        c_pos_q, c_pos_d;
   logic        c_err_q, c_err_d;
   logic        mm_we_q, mm_we_d;
   logic [0:11] mm_adr_q, mm_adr_d;
   logic [0:17] mm_dout_q, mm_dout_d;
   logic [18:0] inc_sum;
   logic [0:17] inc;

   // State and output registers; reset abandons any cycle in flight without a completion pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         adr_q     <= '0;
         wdata_q   <= '0;
         depth_q   <= '0;
         c_rdata_q <= '0;
         c_eadr_q  <= '0;
         c_done_q  <= 1'b0;
         c_pos_q   <= 1'b0;
         c_err_q   <= 1'b0;
         mm_we_q   <= 1'b0;
         mm_adr_q  <= '0;
         mm_dout_q <= '0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         depth_q   <= depth_d;
         c_rdata_q <= c_rdata_d;
         c_eadr_q  <= c_eadr_d;
         c_done_q  <= c_done_d;
         c_pos_q   <= c_pos_d;
         c_err_q   <= c_err_d;
         mm_we_q   <= mm_we_d;
         mm_adr_q  <= mm_adr_d;
         mm_dout_q <= mm_dout_d;
      end
   end

   // Next-state logic; memory bus values are derived from the next state so they are registered
   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      depth_d   = depth_q;
      c_rdata_d = c_rdata_q;
      c_eadr_d  = c_eadr_q;
      c_done_d  = 1'b0;
      c_pos_d   = 1'b0;
      c_err_d   = 1'b0;
      // ones-complement increment: carry out of bit 0 wraps back into bit 17
      inc_sum   = {1'b0, mm_din} + 19'd1;
      inc       = inc_sum[17:0] + {17'd0, inc_sum[18]};

      case (state_q)
         S_IDLE: begin
            if (c_req) begin
               adr_d   = c_adr;
               wdata_d = c_wdata;
               depth_d = '0;
               case (c_op)
                  2'b00:   state_d = S_RD;
                  2'b01:   state_d = S_WR;
                  2'b10:   state_d = S_RMW_RD;
                  default: state_d = S_IND;
               endcase
            end
         end
         S_RD: begin
            c_rdata_d = mm_din;
            c_done_d  = 1'b1;
            state_d   = S_IDLE;
         end
         S_WR: begin
            c_done_d = 1'b1;
            state_d  = S_IDLE;
         end
         S_RMW_RD: begin
            state_d = S_RMW_WR;
         end
         S_RMW_WR: begin
            // mm_dout_q still holds the incremented word being written this cycle
            c_rdata_d = mm_dout_q;
            c_pos_d   = ~mm_dout_q[0];
            c_done_d  = 1'b1;
            state_d   = S_IDLE;
         end
         S_IND: begin
            if (!mm_din[5]) begin
               c_eadr_d  = mm_din[6:17];
               c_rdata_d = mm_din;
               c_done_d  = 1'b1;
               state_d   = S_IDLE;
            end else if (depth_q == DEPTH_LAST) begin
               c_eadr_d = mm_din[6:17];
               c_err_d  = 1'b1;
               c_done_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               adr_d   = mm_din[6:17];
               depth_d = depth_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      mm_adr_d  = (state_d == S_IDLE) ? 12'd0 : adr_d;
      mm_we_d   = (state_d == S_WR) || (state_d == S_RMW_WR);
      mm_dout_d = (state_d == S_WR)     ? wdata_d :
                  (state_d == S_RMW_WR) ? inc     : 18'd0;
   end

   assign c_busy  = (state_q != S_IDLE);
   assign c_done  = c_done_q;
   assign c_rdata = c_rdata_q;
   assign c_eadr  = c_eadr_q;
   assign c_pos   = c_pos_q;
   assign c_err   = c_err_q;
   assign mm_we   = mm_we_q & ~i_rst;
   assign mm_adr  = mm_adr_q;
   assign mm_dout = mm_dout_q;

endmodule

// File: tb/tb_pdp1_mem_ctrl.sv
// tb/tb_pdp1_mem_ctrl.sv - directed table-driven bench for pdp1_mem_ctrl
module tb_pdp1_mem_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        c_req;
   logic [1:0]  c_op;
   logic [11:0] c_adr;
   logic [17:0] c_wdata;
   logic        c_busy;
   logic        c_done;
   logic [17:0] c_rdata;
   logic [11:0] c_eadr;
   logic        c_pos;
   logic        c_err;
   logic        mm_we;
   logic [11:0] mm_adr;
   logic [17:0] mm_din;
   logic [17:0] mm_dout;

   logic [17:0] mem [0:4095];
   logic        pre_we;
   logic [11:0] pre_adr;
   logic [17:0] pre_val;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   pdp1_mem_ctrl #(.MAX_DEFER(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .c_req   (c_req),
      .c_op    (c_op),
      .c_adr   (c_adr),
      .c_wdata (c_wdata),
      .c_busy  (c_busy),
      .c_done  (c_done),
      .c_rdata (c_rdata),
      .c_eadr  (c_eadr),
      .c_pos   (c_pos),
      .c_err   (c_err),
      .mm_we   (mm_we),
      .mm_adr  (mm_adr),
      .mm_din  (mm_din),
      .mm_dout (mm_dout)
   );

   // core memory model: combinational read, write on the clock edge
   assign mm_din = mem[mm_adr];

   always @(posedge i_clk) begin
      if (mm_we) mem[mm_adr] <= mm_dout;
      else if (pre_we) mem[pre_adr] <= pre_val;
   end

   typedef struct {
      logic [1:0]  op;
      logic [11:0] adr;
      logic [17:0] wdata;
      logic        pre;
      logic [11:0] pre_adr;
      logic [17:0] pre_val;
      int          lat;
      logic [17:0] rdata;
      logic [11:0] eadr;
      logic        pos;
      logic        err;
      int          wes;
      logic [11:0] madr;
      logic [17:0] mval;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0o expected %0o", name, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [17:0] v);
      @(negedge i_clk);
      pre_we = 1'b1; pre_adr = a; pre_val = v;
      @(posedge i_clk);
      @(negedge i_clk);
      pre_we = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      int wes;
      logic badadr;
      logic done;
      if (v.pre) preload(v.pre_adr, v.pre_val);
      @(negedge i_clk);
      c_req = 1'b1; c_op = v.op; c_adr = v.adr; c_wdata = v.wdata;
      @(posedge i_clk);
      @(negedge i_clk);
      c_req = 1'b0;
      lat = 1; wes = 0; badadr = 1'b0; done = 1'b0;
      while (!done && lat < 40) begin
         if (mm_we) begin
            wes++;
            if (mm_adr !== v.adr) badadr = 1'b1;
         end
         if (c_done) done = 1'b1;
         else begin
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
         end
      end
      check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
      check($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d_rdata", idx), 32'(c_rdata), 32'(v.rdata));
      check($sformatf("v%0d_eadr", idx), 32'(c_eadr), 32'(v.eadr));
      check($sformatf("v%0d_pos", idx), 32'(c_pos), 32'(v.pos));
      check($sformatf("v%0d_err", idx), 32'(c_err), 32'(v.err));
      check($sformatf("v%0d_busy", idx), 32'(c_busy), 32'd0);
      check($sformatf("v%0d_we_cycles", idx), 32'(wes), 32'(v.wes));
      check($sformatf("v%0d_we_adr", idx), 32'(badadr), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      check($sformatf("v%0d_mem", idx), 32'(mem[v.madr]), 32'(v.mval));
      check($sformatf("v%0d_pulse_clear", idx), {29'd0, c_done, c_err, c_pos}, 32'd0);
   endtask

   initial begin
      logic [1:0]  bop [4];
      logic [17:0] bexp [4];
      int n, cyc, wes, extra;

      tbl[0] = '{2'b00, 12'o0100, 18'o0,      1'b1, 12'o0100, 18'o123456, 2, 18'o123456, 12'o0,    1'b0, 1'b0, 0, 12'o0100, 18'o123456};
      tbl[1] = '{2'b01, 12'o0200, 18'o654321, 1'b0, 12'o0,    18'o0,      2, 18'o123456, 12'o0,    1'b0, 1'b0, 1, 12'o0200, 18'o654321};
      tbl[2] = '{2'b00, 12'o0200, 18'o0,      1'b0, 12'o0,    18'o0,      2, 18'o654321, 12'o0,    1'b0, 1'b0, 0, 12'o0200, 18'o654321};
      tbl[3] = '{2'b10, 12'o0300, 18'o0,      1'b1, 12'o0300, 18'o777777, 3, 18'o000001, 12'o0,    1'b1, 1'b0, 1, 12'o0300, 18'o000001};
      tbl[4] = '{2'b10, 12'o0301, 18'o0,      1'b1, 12'o0301, 18'o377777, 3, 18'o400000, 12'o0,    1'b0, 1'b0, 1, 12'o0301, 18'o400000};
      tbl[5] = '{2'b10, 12'o0302, 18'o0,      1'b1, 12'o0302, 18'o000005, 3, 18'o000006, 12'o0,    1'b1, 1'b0, 1, 12'o0302, 18'o000006};
      tbl[6] = '{2'b11, 12'o0010, 18'o0,      1'b1, 12'o0010, 18'o010020, 3, 18'o000555, 12'o0555, 1'b0, 1'b0, 0, 12'o0020, 18'o000555};
      tbl[7] = '{2'b11, 12'o0030, 18'o0,      1'b1, 12'o0030, 18'o010030, 9, 18'o000555, 12'o0030, 1'b0, 1'b1, 0, 12'o0030, 18'o010030};
      tbl[8] = '{2'b11, 12'o0040, 18'o0,      1'b1, 12'o0040, 18'o000123, 2, 18'o000123, 12'o0123, 1'b0, 1'b0, 0, 12'o0040, 18'o000123};

      i_rst = 1'b1; c_req = 1'b0; c_op = 2'b00; c_adr = '0; c_wdata = '0;
      pre_we = 1'b0; pre_adr = '0; pre_val = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_flags", {27'd0, c_busy, c_done, c_pos, c_err, mm_we}, 32'd0);
      check("rst_rdata", 32'(c_rdata), 32'd0);
      check("rst_eadr", 32'(c_eadr), 32'd0);
      check("rst_mm_bus", {2'd0, mm_adr, mm_dout}, 32'd0);
      i_rst = 1'b0;

      preload(12'o0020, 18'o000555);
      for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

      // back-to-back: c_req held high, next op presented in each c_done cycle
      bop[0] = 2'b01; bexp[0] = 18'o0;
      bop[1] = 2'b00; bexp[1] = 18'o111111;
      bop[2] = 2'b10; bexp[2] = 18'o111112;
      bop[3] = 2'b00; bexp[3] = 18'o111112;
      @(negedge i_clk);
      c_req = 1'b1; c_op = bop[0]; c_adr = 12'o0400; c_wdata = 18'o111111;
      n = 0; cyc = 0; wes = 0;
      while (n < 4 && cyc < 60) begin
         @(posedge i_clk);
         @(negedge i_clk);
         cyc++;
         if (mm_we) wes++;
         if (c_done) begin
            if (n > 0) check($sformatf("b2b%0d_rdata", n), 32'(c_rdata), 32'(bexp[n]));
            check($sformatf("b2b%0d_busy", n), 32'(c_busy), 32'd0);
            n++;
            if (n < 4) c_op = bop[n];
            else c_req = 1'b0;
         end
      end
      c_req = 1'b0;
      check("b2b_done_count", 32'(n), 32'd4);
      check("b2b_cycles", 32'(cyc), 32'd9);
      check("b2b_we_cycles", 32'(wes), 32'd2);
      extra = 0;
      repeat (4) begin
         @(posedge i_clk);
         @(negedge i_clk);
         if (c_done || mm_we) extra++;
      end
      check("b2b_no_extra", 32'(extra), 32'd0);
      check("b2b_mem", 32'(mem[12'o0400]), 32'(18'o111112));

      // reset landing in the RMW write cycle must suppress the write and the completion
      preload(12'o0500, 18'o000007);
      @(negedge i_clk);
      c_req = 1'b1; c_op = 2'b10; c_adr = 12'o0500;
      @(posedge i_clk);
      @(negedge i_clk);
      c_req = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check("rmw_wr_we", 32'(mm_we), 32'd1);
      i_rst = 1'b1;
      #1;
      check("rst_gate_we", 32'(mm_we), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      check("rst2_flags", {27'd0, c_busy, c_done, c_pos, c_err, mm_we}, 32'd0);
      check("rst2_rdata", 32'(c_rdata), 32'd0);
      check("rst2_eadr", 32'(c_eadr), 32'd0);
      check("rst2_mm_bus", {2'd0, mm_adr, mm_dout}, 32'd0);
      check("rst2_mem", 32'(mem[12'o0500]), 32'(18'o000007));
      i_rst = 1'b0;
      extra = 0;
      repeat (3) begin
         @(posedge i_clk);
         @(negedge i_clk);
         if (c_done || c_busy || mm_we) extra++;
      end
      check("rst2_quiet", 32'(extra), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
